wave_pwm_dac: RTL and testbench

WAVE_PWM_DAC -- requirements
Module: wave_pwm_dac

---
 rtl/wave_pkg.sv | 9 +
 rtl/wave_pwm_core.sv | 81 ++++++++
 rtl/wave_pwm_dac.sv | 72 +++++++
 tb/tb_wave_pwm_dac.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// Shared constants and types for the wave PWM DAC.
// Holds the default sample width and the sample type.
package wave_pkg;

  localparam int WAVE_WIDTH = 8;

  typedef logic [WAVE_WIDTH-1:0] sample_t;

endpackage

// File: rtl/wave_pwm_core.sv
// PWM core: period counter, duty comparator, optional sigma-delta.
// Sigma-delta path is built only with WAVE_PWM_DAC_SD_EN defined.
module wave_pwm_core
  import wave_pkg::*;
#(
  parameter int WIDTH = WAVE_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
`ifdef WAVE_PWM_DAC_SD_EN
  input  logic             sd_mode,
`endif
  input  logic [WIDTH-1:0] active,
  output logic             wrap,
  output logic             pwm_out,
  output logic             period_start
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] cnt;
  logic             pwm_next;

  assign wrap = ena && (cnt == CNT_MAX);

`ifdef WAVE_PWM_DAC_SD_EN
  logic [WIDTH-1:0] acc;
  logic [WIDTH:0]   sum;
  logic             sd_q;

  assign sum = {1'b0, acc} + {1'b0, active};

  // Accumulator restarts from zero whenever the mode flips.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      sd_q <= 1'b0;
    end else begin
      sd_q <= sd_mode;
      if (sd_mode != sd_q)
        acc <= '0;
      else if (ena && sd_mode)
        acc <= sum[WIDTH-1:0];
    end
  end

  // Carry out is the bitstream in sigma-delta mode.
  always_comb begin
    pwm_next = (cnt < active);
    if (sd_mode)
      pwm_next = sum[WIDTH];
  end
`else
  // Plain PWM compare.
  always_comb begin
    pwm_next = (cnt < active);
  end
`endif

  // Free-running period counter, frozen while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (ena)
      cnt <= cnt + WIDTH'(1);
  end

  // Registered output bit and period marker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      period_start <= wrap;
      if (ena)
        pwm_out <= pwm_next;
    end
  end

endmodule

// File: rtl/wave_pwm_dac.sv
// Wave PWM DAC top: sample handshake, hold/active duty, underrun.
// Define WAVE_PWM_DAC_SD_EN to add the sd_mode sigma-delta input.
module wave_pwm_dac
  import wave_pkg::*;
#(
  parameter int WIDTH = WAVE_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
`ifdef WAVE_PWM_DAC_SD_EN
  input  logic             sd_mode,
`endif
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             pwm_out,
  output logic             period_start,
  output logic             underrun,
  input  logic             clr_underrun
);

  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] active;
  logic             hold_full;
  logic             accept;
  logic             wrap;

  assign sample_ready = !hold_full;
  assign accept       = sample_valid && !hold_full;

  // Hold register feeds the active duty at each period boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
      active    <= '0;
    end else if (wrap && hold_full) begin
      active    <= hold;
      hold_full <= 1'b0;
    end else if (accept) begin
      hold      <= sample_in;
      hold_full <= 1'b1;
    end
  end

  // Sticky underrun; a new underrun beats a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      underrun <= 1'b0;
    else if (wrap && !hold_full)
      underrun <= 1'b1;
    else if (clr_underrun)
      underrun <= 1'b0;
  end

  wave_pwm_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
`ifdef WAVE_PWM_DAC_SD_EN
    .sd_mode     (sd_mode),
`endif
    .active      (active),
    .wrap        (wrap),
    .pwm_out     (pwm_out),
    .period_start(period_start)
  );

endmodule

// File: tb/tb_wave_pwm_dac.sv
// Directed bench for wave_pwm_dac (WIDTH=8, 256-cycle period).
// Sigma-delta scenario runs only with WAVE_PWM_DAC_SD_EN defined.
module tb_wave_pwm_dac;
  import wave_pkg::*;

  logic    clk = 1'b0;
  logic    rst;
  logic    ena;
  sample_t sample_in;
  logic    sample_valid;
  logic    sample_ready;
  logic    pwm_out;
  logic    period_start;
  logic    underrun;
  logic    clr_underrun;
`ifdef WAVE_PWM_DAC_SD_EN
  logic    sd_mode;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  wave_pwm_dac #(
    .WIDTH(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
`ifdef WAVE_PWM_DAC_SD_EN
    .sd_mode     (sd_mode),
`endif
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .pwm_out     (pwm_out),
    .period_start(period_start),
    .underrun    (underrun),
    .clr_underrun(clr_underrun)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    ena = 1'b1;
    sample_valid = 1'b0;
    sample_in = '0;
    clr_underrun = 1'b0;
`ifdef WAVE_PWM_DAC_SD_EN
    sd_mode = 1'b0;
`endif
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic push(input logic [7:0] s);
    int n;
    n = 0;
    sample_in = s;
    sample_valid = 1'b1;
    while (!sample_ready && n < 600) begin
      cyc(1);
      n++;
    end
    cyc(1);
    sample_valid = 1'b0;
  endtask

  task automatic wait_ps(output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    while (n < 600 && !ok) begin
      cyc(1);
      n++;
      ok = period_start;
    end
  endtask

  task automatic measure(output int ones, output bit ps_ok);
    int pulses;
    pulses = 0;
    ones = 0;
    for (int i = 1; i <= 256; i++) begin
      cyc(1);
      ones += int'(pwm_out);
      pulses += int'(period_start);
    end
    ps_ok = (pulses == 1) && period_start;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    ena = 1'b1;
    sample_valid = 1'b0;
    sample_in = '0;
    clr_underrun = 1'b0;
`ifdef WAVE_PWM_DAC_SD_EN
    sd_mode = 1'b0;
`endif
    cyc(2);
    total++;
    if (sample_ready !== 1'b1)
      $display("FAIL rst_ready: got %b want 1", sample_ready);
    else passed++;
    total++;
    if (pwm_out !== 1'b0)
      $display("FAIL rst_pwm: got %b want 0", pwm_out);
    else passed++;
    total++;
    if (period_start !== 1'b0)
      $display("FAIL rst_ps: got %b want 0", period_start);
    else passed++;
    total++;
    if (underrun !== 1'b0)
      $display("FAIL rst_underrun: got %b want 0", underrun);
    else passed++;
  endtask

  task automatic test_duty_40;
    bit ok;
    int ones;
    do_reset();
    sample_in = 8'h40;
    sample_valid = 1'b1;
    wait_ps(ok);
    total++;
    if (ok !== 1'b1)
      $display("FAIL d40_wait: got %b want 1", ok);
    else passed++;
    for (int p = 0; p < 2; p++) begin
      measure(ones, ok);
      total++;
      if (ones != 64)
        $display("FAIL d40_ones%0d: got %0d want 64", p, ones);
      else passed++;
      total++;
      if (ok !== 1'b1)
        $display("FAIL d40_ps%0d: got %b want 1", p, ok);
      else passed++;
    end
    total++;
    if (underrun !== 1'b0)
      $display("FAIL d40_underrun: got %b want 0", underrun);
    else passed++;
    sample_valid = 1'b0;
  endtask

  task automatic test_duty_00_ff;
    bit ok;
    int ones;
    do_reset();
    push(8'h00);
    wait_ps(ok);
    total++;
    if (ok !== 1'b1)
      $display("FAIL d00_wait: got %b want 1", ok);
    else passed++;
    sample_in = 8'hFF;
    sample_valid = 1'b1;
    measure(ones, ok);
    total++;
    if (ones != 0)
      $display("FAIL d00_ones: got %0d want 0", ones);
    else passed++;
    total++;
    if (ok !== 1'b1)
      $display("FAIL d00_ps: got %b want 1", ok);
    else passed++;
    measure(ones, ok);
    total++;
    if (ones != 255)
      $display("FAIL dff_ones: got %0d want 255", ones);
    else passed++;
    total++;
    if (ok !== 1'b1)
      $display("FAIL dff_ps: got %b want 1", ok);
    else passed++;
    sample_valid = 1'b0;
  endtask

  task automatic test_underrun;
    bit ok;
    int ones;
    do_reset();
    push(8'h20);
    wait_ps(ok);
    total++;
    if (ok !== 1'b1 || underrun !== 1'b0)
      $display("FAIL ur_first: got ps=%b ur=%b want 1 0", ok, underrun);
    else passed++;
    measure(ones, ok);
    total++;
    if (ones != 32)
      $display("FAIL ur_ones1: got %0d want 32", ones);
    else passed++;
    total++;
    if (underrun !== 1'b1)
      $display("FAIL ur_set: got %b want 1", underrun);
    else passed++;
    measure(ones, ok);
    total++;
    if (ones != 32)
      $display("FAIL ur_repeat: got %0d want 32", ones);
    else passed++;
    clr_underrun = 1'b1;
    cyc(1);
    clr_underrun = 1'b0;
    total++;
    if (underrun !== 1'b0)
      $display("FAIL ur_clr: got %b want 0", underrun);
    else passed++;
    cyc(254);
    clr_underrun = 1'b1;
    cyc(1);
    clr_underrun = 1'b0;
    total++;
    if (underrun !== 1'b1)
      $display("FAIL ur_set_wins: got %b want 1", underrun);
    else passed++;
    total++;
    if (period_start !== 1'b1)
      $display("FAIL ur_wrap_ps: got %b want 1", period_start);
    else passed++;
  endtask

  task automatic test_wrap_accept;
    bit ok;
    int ones;
    do_reset();
    push(8'h10);
    wait_ps(ok);
    total++;
    if (ok !== 1'b1)
      $display("FAIL wa_wait: got %b want 1", ok);
    else passed++;
    cyc(255);
    sample_in = 8'h60;
    sample_valid = 1'b1;
    cyc(1);
    sample_valid = 1'b0;
    total++;
    if (underrun !== 1'b1)
      $display("FAIL wa_underrun: got %b want 1", underrun);
    else passed++;
    total++;
    if (sample_ready !== 1'b0)
      $display("FAIL wa_held: got %b want 0", sample_ready);
    else passed++;
    measure(ones, ok);
    total++;
    if (ones != 16)
      $display("FAIL wa_old_duty: got %0d want 16", ones);
    else passed++;
    measure(ones, ok);
    total++;
    if (ones != 96)
      $display("FAIL wa_new_duty: got %0d want 96", ones);
    else passed++;
  endtask

  task automatic test_ena_freeze;
    bit   ok;
    bit   frz_ok;
    logic held;
    int   i;
    do_reset();
    sample_in = 8'h80;
    sample_valid = 1'b1;
    wait_ps(ok);
    frz_ok = 1'b1;
    held = 1'b0;
    i = 0;
    while (i < 400) begin
      cyc(1);
      i++;
      if (i == 100) begin
        held = pwm_out;
        ena = 1'b0;
      end else if (i > 100 && i <= 110) begin
        if (pwm_out !== held || period_start !== 1'b0)
          frz_ok = 1'b0;
        if (i == 110)
          ena = 1'b1;
      end else if (period_start) begin
        break;
      end
    end
    total++;
    if (held !== 1'b1)
      $display("FAIL ena_pre: got %b want 1", held);
    else passed++;
    total++;
    if (frz_ok !== 1'b1)
      $display("FAIL ena_frozen: got %b want 1", frz_ok);
    else passed++;
    total++;
    if (i != 266)
      $display("FAIL ena_stretch: got %0d want 266", i);
    else passed++;
  endtask

  task automatic test_reset_mid;
    bit ok;
    int ones;
    cyc(10);
    total++;
    if (pwm_out !== 1'b1 || sample_ready !== 1'b0)
      $display("FAIL rm_pre: got pwm=%b rdy=%b want 1 0", pwm_out, sample_ready);
    else passed++;
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (pwm_out !== 1'b0 || sample_ready !== 1'b1)
      $display("FAIL rm_now: got pwm=%b rdy=%b want 0 1", pwm_out, sample_ready);
    else passed++;
    total++;
    if (period_start !== 1'b0 || underrun !== 1'b0)
      $display("FAIL rm_flags: got ps=%b ur=%b want 0 0", period_start, underrun);
    else passed++;
    sample_valid = 1'b0;
    cyc(1);
    rst = 1'b0;
    measure(ones, ok);
    total++;
    if (ones != 0)
      $display("FAIL rm_duty: got %0d want 0", ones);
    else passed++;
    total++;
    if (ok !== 1'b1)
      $display("FAIL rm_ps: got %b want 1", ok);
    else passed++;
    total++;
    if (underrun !== 1'b1)
      $display("FAIL rm_hold_gone: got %b want 1", underrun);
    else passed++;
  endtask

`ifdef WAVE_PWM_DAC_SD_EN
  task automatic test_sigma_delta;
    bit   ok;
    bit   alt_ok;
    int   ones;
    logic prev;
    do_reset();
    push(8'h80);
    wait_ps(ok);
    sd_mode = 1'b1;
    cyc(4);
    prev = pwm_out;
    alt_ok = 1'b1;
    ones = 0;
    for (int k = 0; k < 256; k++) begin
      cyc(1);
      if (pwm_out === prev)
        alt_ok = 1'b0;
      prev = pwm_out;
      ones += int'(pwm_out);
    end
    total++;
    if (alt_ok !== 1'b1)
      $display("FAIL sd_alt: got %b want 1", alt_ok);
    else passed++;
    total++;
    if (ones != 128)
      $display("FAIL sd_ones: got %0d want 128", ones);
    else passed++;
    sd_mode = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_duty_40();
    test_duty_00_ff();
    test_underrun();
    test_wrap_accept();
    test_ena_freeze();
    test_reset_mid();
`ifdef WAVE_PWM_DAC_SD_EN
    test_sigma_delta();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
